// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter between two cores: one buffered word per core,
// round-robin grant, strobed bytes serialized LSB-first, baud divisor updated only when idle.
module uart_tx_arbiter #(
  parameter int unsigned DIV_RESET = 87,
  parameter int unsigned DIV_MIN   = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Req0_Valid,
  input  logic [31:0] i_Req0_Word,
  input  logic [3:0]  i_Req0_Wstrb,
  output logic        o_Req0_Ready,
  output logic        o_Req0_Done,
  input  logic        i_Req1_Valid,
  input  logic [31:0] i_Req1_Word,
  input  logic [3:0]  i_Req1_Wstrb,
  output logic        o_Req1_Ready,
  output logic        o_Req1_Done,
  input  logic        i_Cfg_We,
  input  logic [7:0]  i_Cfg_Div,
  output logic [7:0]  o_Clks_Per_Bit,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  output logic        o_Busy
);

  localparam logic [7:0] DIV_RESET_B = 8'(DIV_RESET);
  localparam logic [7:0] DIV_MIN_B   = 8'(DIV_MIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  state_t      state, state_next;

  logic        pend0, pend1;
  logic [31:0] word0, word1, work_word;
  logic [3:0]  strb0, strb1, work_strb;
  logic        owner, last_core;
  logic [7:0]  div_shadow, clks;
  logic        cfg_pend;
  logic        tx_dv, done0, done1;
  logic [7:0]  tx_byte;

  logic        grant, grant_core;
  logic [31:0] grant_word, src_word;
  logic [3:0]  grant_strb, src_strb;
  logic        load_dv, finish, finish_core;
  logic [1:0]  src_idx;
  logic [7:0]  next_byte;

  function automatic logic [1:0] low_idx(input logic [3:0] s);
    logic [1:0] idx;
    idx = 2'd0;
    if (s[0])      idx = 2'd0;
    else if (s[1]) idx = 2'd1;
    else if (s[2]) idx = 2'd2;
    else if (s[3]) idx = 2'd3;
    return idx;
  endfunction

  // The transmitter is never reset, so a byte may still be in flight after our reset.
  assign grant      = (state == S_IDLE) && !i_Tx_Active && !i_Tx_Done && (pend0 || pend1);
  assign grant_core = (pend0 && pend1) ? ~last_core : pend1;
  assign grant_word = grant_core ? word1 : word0;
  assign grant_strb = grant_core ? strb1 : strb0;

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_next  = state;
    load_dv     = 1'b0;
    finish      = 1'b0;
    finish_core = owner;
    src_word    = work_word;
    src_strb    = work_strb;
    case (state)
      S_IDLE: begin
        if (grant) begin
          src_word = grant_word;
          src_strb = grant_strb;
          if (|grant_strb) begin
            state_next = S_ISSUE;
            load_dv    = 1'b1;
          end else begin
            finish      = 1'b1;
            finish_core = grant_core;
          end
        end
      end
      S_ISSUE:     state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_Tx_Done) state_next = S_DRAIN;
      S_DRAIN: begin
        if (!i_Tx_Done) begin
          if (|work_strb) begin
            state_next = S_ISSUE;
            load_dv    = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign src_idx   = low_idx(src_strb);
  assign next_byte = src_word[{src_idx, 3'b000} +: 8];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state      <= S_IDLE;
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      strb0      <= 4'd0;
      strb1      <= 4'd0;
      work_strb  <= 4'd0;
      owner      <= 1'b0;
      last_core  <= 1'b1;
      tx_dv      <= 1'b0;
      tx_byte    <= 8'd0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      clks       <= DIV_RESET_B;
      div_shadow <= DIV_RESET_B;
      cfg_pend   <= 1'b0;
    end else begin
      state <= state_next;
      tx_dv <= load_dv;
      if (load_dv) tx_byte <= next_byte;
      done0 <= finish && !finish_core;
      done1 <= finish && finish_core;

      // Accept and grant never hit the same buffer in one cycle: accept needs it empty.
      if (i_Req0_Valid && !pend0) begin
        pend0 <= 1'b1;
        strb0 <= i_Req0_Wstrb;
      end
      if (i_Req1_Valid && !pend1) begin
        pend1 <= 1'b1;
        strb1 <= i_Req1_Wstrb;
      end
      if (grant) begin
        owner     <= grant_core;
        last_core <= grant_core;
        work_strb <= grant_strb;
        if (grant_core) pend1 <= 1'b0;
        else            pend0 <= 1'b0;
      end
      if (state == S_ISSUE) work_strb <= work_strb & ~(4'b0001 << low_idx(work_strb));

      // A write in the same cycle as an apply keeps cfg_pend set for the newer value.
      if (cfg_pend && (state == S_IDLE) && !grant) begin
        clks     <= div_shadow;
        cfg_pend <= 1'b0;
      end
      if (i_Cfg_We) begin
        div_shadow <= (i_Cfg_Div < DIV_MIN_B) ? DIV_MIN_B : i_Cfg_Div;
        cfg_pend   <= 1'b1;
      end
    end
  end

  // NOTE: payload registers carry no reset; the pend/strobe flags qualify them.
  always_ff @(posedge i_Clock) begin
    if (i_Req0_Valid && !pend0) word0 <= i_Req0_Word;
    if (i_Req1_Valid && !pend1) word1 <= i_Req1_Word;
    if (grant) work_word <= grant_word;
  end

  assign o_Req0_Ready   = ~pend0;
  assign o_Req1_Ready   = ~pend1;
  assign o_Req0_Done    = done0;
  assign o_Req1_Done    = done1;
  assign o_Clks_Per_Bit = clks;
  assign o_Tx_DV        = tx_dv;
  assign o_Tx_Byte      = tx_byte;
  assign o_Busy         = (state != S_IDLE) || pend0 || pend1;

endmodule
